// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and constants for the L2 port arbiter
package l2_arb_pkg;

    localparam int L2_ADDR_W  = 30;
    localparam int L2_BLOCK_W = 128;

    // Requester identities, also used as the one-bit owner/last encoding
    localparam logic REQ_IC = 1'b0;
    localparam logic REQ_DC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Pick a winner among pending requests; ties go to the side not granted last
    function automatic logic arb_pick(input logic ic_req, input logic dc_req, input logic last);
        logic winner;
        if (ic_req && dc_req) begin
            winner = (last == REQ_IC) ? REQ_DC : REQ_IC;
        end else if (dc_req) begin
            winner = REQ_DC;
        end else begin
            winner = REQ_IC;
        end
        return winner;
    endfunction

endpackage

// File: rtl/l2_arb_watchdog.sv
// rtl/l2_arb_watchdog.sv - progress counter that flags a hung L2 transaction
module l2_arb_watchdog #(
    parameter int TIMEOUT = 1023,
    parameter int CNTW    = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNTW-1:0] LIMIT = CNTW'(TIMEOUT);
    localparam logic [CNTW-1:0] ONE   = CNTW'(1);

    logic [CNTW-1:0] cnt;

    // Count non-stalled, not-yet-ready cycles; held at zero whenever cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + ONE;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - shares one L2 port between I-side and D-side L1 caches
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int TIMEOUT = 1023,
    parameter int CNTW    = 10
) (
    input  logic                  clk,
    input  logic                  proc_reset_n,
    input  logic                  ic_read,
    input  logic                  ic_write,
    input  logic [L2_ADDR_W-1:0]  ic_addr,
    input  logic [L2_BLOCK_W-1:0] ic_wdata,
    output logic [L2_BLOCK_W-1:0] ic_rdata,
    output logic                  ic_ready,
    output logic                  ic_stall,
    input  logic                  dc_read,
    input  logic                  dc_write,
    input  logic [L2_ADDR_W-1:0]  dc_addr,
    input  logic [L2_BLOCK_W-1:0] dc_wdata,
    output logic [L2_BLOCK_W-1:0] dc_rdata,
    output logic                  dc_ready,
    output logic                  dc_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [L2_ADDR_W-1:0]  mem_addr,
    output logic [L2_BLOCK_W-1:0] mem_wdata,
    input  logic [L2_BLOCK_W-1:0] mem_rdata,
    input  logic                  mem_ready,
    input  logic                  mem_stall,
    output logic                  err_timeout
);

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last, last_nxt;
    logic   was_write, was_write_nxt;
    logic   err_nxt;

    logic   ic_req, dc_req, own_req, own_write;
    logic   busy, own_dc, winner;
    logic   wd_clear, wd_enable, wd_expired;

    assign ic_req    = ic_read | ic_write;
    assign dc_req    = dc_read | dc_write;
    assign busy      = (state == BUSY);
    assign own_dc    = (owner == REQ_DC);
    assign own_req   = own_dc ? dc_req : ic_req;
    assign own_write = own_dc ? dc_write : ic_write;
    assign winner    = arb_pick(ic_req, dc_req, last);

    // Counter only runs in BUSY, so every entry into BUSY starts from zero
    assign wd_clear  = !busy;
    assign wd_enable = busy && !mem_stall && !mem_ready;

    l2_arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (proc_reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State and ownership registers
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state       <= IDLE;
            owner       <= REQ_IC;
            last        <= REQ_IC;
            was_write   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last        <= last_nxt;
            was_write   <= was_write_nxt;
            err_timeout <= err_nxt;
        end
    end

    // Grant, completion, writeback hold and abort decisions
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_nxt      = last;
        was_write_nxt = was_write;
        err_nxt       = err_timeout;
        case (state)
            IDLE: begin
                if (ic_req || dc_req) begin
                    state_nxt     = BUSY;
                    owner_nxt     = winner;
                    last_nxt      = winner;
                    was_write_nxt = (winner == REQ_DC) ? dc_write : ic_write;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nxt = was_write ? HOLD : IDLE;
                end else if (wd_expired) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                // Keeps a writeback and its allocate read together as one grant
                if (own_req) begin
                    state_nxt     = BUSY;
                    was_write_nxt = own_write;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Port mux toward L2 and response steering back to the owner
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ic_ready  = 1'b0;
        ic_stall  = 1'b0;
        dc_ready  = 1'b0;
        dc_stall  = 1'b0;
        ic_rdata  = '0;
        dc_rdata  = '0;
        if (busy) begin
            ic_rdata = mem_rdata;
            dc_rdata = mem_rdata;
            if (own_dc) begin
                mem_read  = dc_read;
                mem_write = dc_write;
                mem_addr  = dc_addr;
                mem_wdata = dc_wdata;
                dc_ready  = mem_ready;
                dc_stall  = mem_stall;
            end else begin
                mem_read  = ic_read;
                mem_write = ic_write;
                mem_addr  = ic_addr;
                mem_wdata = ic_wdata;
                ic_ready  = mem_ready;
                ic_stall  = mem_stall;
            end
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - self-checking bench for l2_port_arbiter
module tb_l2_port_arbiter;

    localparam int TMO = 8;
    localparam logic [127:0] IC_WD = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    localparam logic [127:0] DC_WD = 128'h2222_2222_2222_2222_2222_2222_2222_2222;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         ic_read, ic_write, dc_read, dc_write;
    logic [29:0]  ic_addr, dc_addr, mem_addr;
    logic [127:0] ic_wdata, dc_wdata, ic_rdata, dc_rdata, mem_wdata, mem_rdata;
    logic         ic_ready, ic_stall, dc_ready, dc_stall;
    logic         mem_read, mem_write, mem_ready, mem_stall, err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l2_port_arbiter #(.TIMEOUT(TMO), .CNTW(10)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .ic_read(ic_read), .ic_write(ic_write), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
        .ic_rdata(ic_rdata), .ic_ready(ic_ready), .ic_stall(ic_stall),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rdata(dc_rdata), .dc_ready(dc_ready), .dc_stall(dc_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic        ic_rd, ic_wr, dc_rd, dc_wr;
        logic [29:0] ic_a, dc_a;
        int          lat;
        logic        exp_dc, exp_rd, exp_wr;
        logic [29:0] exp_addr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic ic_rd, input logic ic_wr, input logic dc_rd, input logic dc_wr,
                                input logic [29:0] ic_a, input logic [29:0] dc_a, input int lat,
                                input logic exp_dc, input logic exp_rd, input logic exp_wr,
                                input logic [29:0] exp_addr);
        vec_t v;
        v.ic_rd = ic_rd; v.ic_wr = ic_wr; v.dc_rd = dc_rd; v.dc_wr = dc_wr;
        v.ic_a = ic_a; v.dc_a = dc_a; v.lat = lat;
        v.exp_dc = exp_dc; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
        return v;
    endfunction

    task automatic drop_all();
        ic_read = 1'b0; ic_write = 1'b0; dc_read = 1'b0; dc_write = 1'b0;
    endtask

    // Starts in an IDLE cycle just after a rising edge; leaves in the same position
    task automatic run_vec(input int idx, input vec_t v);
        logic [127:0] pat;
        pat = {4{32'hC0DE_0000 + 32'(idx)}};
        ic_read = v.ic_rd; ic_write = v.ic_wr; ic_addr = v.ic_a;
        dc_read = v.dc_rd; dc_write = v.dc_wr; dc_addr = v.dc_a;
        @(negedge clk);
        chk1($sformatf("v%0d_grant_latency", idx), mem_read | mem_write, 1'b0);
        tick();
        for (int k = 1; k <= v.lat; k++) begin
            if (k == v.lat) begin
                mem_ready = 1'b1;
                mem_rdata = pat;
            end
            @(negedge clk);
            if (k == 1) begin
                chk1($sformatf("v%0d_mem_read", idx), mem_read, v.exp_rd);
                chk1($sformatf("v%0d_mem_write", idx), mem_write, v.exp_wr);
                chkw($sformatf("v%0d_mem_addr", idx), 128'(mem_addr), 128'(v.exp_addr));
                chkw($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.exp_dc ? DC_WD : IC_WD);
            end
            if (k < v.lat) begin
                chk1($sformatf("v%0d_early_ready", idx), ic_ready | dc_ready, 1'b0);
            end else begin
                chk1($sformatf("v%0d_winner_ready", idx), v.exp_dc ? dc_ready : ic_ready, 1'b1);
                chk1($sformatf("v%0d_loser_ready", idx), v.exp_dc ? ic_ready : dc_ready, 1'b0);
                chkw($sformatf("v%0d_rdata", idx), v.exp_dc ? dc_rdata : ic_rdata, pat);
            end
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        drop_all();
        tick();
    endtask

    initial begin
        int bad;

        // Both-tie sequence from reset starts with DC, then alternates
        vecs[0]  = mk(1,0,1,0, 30'h0000100, 30'h0000010, 3, 1,1,0, 30'h0000010);
        vecs[1]  = mk(1,0,1,0, 30'h0000101, 30'h0000011, 1, 0,1,0, 30'h0000101);
        vecs[2]  = mk(1,0,1,0, 30'h0000102, 30'h0000012, 2, 1,1,0, 30'h0000012);
        vecs[3]  = mk(1,0,1,0, 30'h0000103, 30'h0000013, 2, 0,1,0, 30'h0000103);
        vecs[4]  = mk(1,0,1,0, 30'h0000104, 30'h0000014, 1, 1,1,0, 30'h0000014);
        vecs[5]  = mk(1,0,1,0, 30'h0000105, 30'h0000015, 3, 0,1,0, 30'h0000105);
        vecs[6]  = mk(1,0,1,0, 30'h0000106, 30'h0000016, 1, 1,1,0, 30'h0000016);
        vecs[7]  = mk(1,0,1,0, 30'h0000107, 30'h0000017, 2, 0,1,0, 30'h0000107);
        vecs[8]  = mk(0,1,0,0, 30'h2AAAAA5, 30'h0000000, 2, 0,0,1, 30'h2AAAAA5);
        vecs[9]  = mk(0,0,1,1, 30'h0000000, 30'h3FFFFFFF, 1, 1,1,1, 30'h3FFFFFFF);
        vecs[10] = mk(0,1,1,0, 30'h0000AAA, 30'h0000BBB, 2, 0,0,1, 30'h0000AAA);
        vecs[11] = mk(0,0,0,1, 30'h0000000, 30'h0000CCC, 4, 1,0,1, 30'h0000CCC);

        proc_reset_n = 1'b0;
        drop_all();
        ic_addr = '0; dc_addr = '0;
        ic_wdata = IC_WD; dc_wdata = DC_WD;
        mem_rdata = '1; mem_ready = 1'b1; mem_stall = 1'b1;
        #12;
        chk1("rst_mem_rw", mem_read | mem_write, 1'b0);
        chkw("rst_mem_addr", 128'(mem_addr), 128'd0);
        chkw("rst_mem_wdata", mem_wdata, 128'd0);
        chk1("rst_ready", ic_ready | dc_ready, 1'b0);
        chk1("rst_stall", ic_stall | dc_stall, 1'b0);
        chkw("rst_rdata", ic_rdata | dc_rdata, 128'd0);
        chk1("rst_err", err_timeout, 1'b0);
        mem_rdata = '0; mem_ready = 1'b0; mem_stall = 1'b0;
        tick();
        proc_reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // DC writeback then allocate read holds the port against a waiting IC
        dc_write = 1'b1; dc_addr = 30'h3FFFFF0;
        tick();
        ic_read = 1'b1; ic_addr = 30'h0000444;
        @(negedge clk);
        chk1("hold_wb_write", mem_write, 1'b1);
        chkw("hold_wb_addr", 128'(mem_addr), 128'(30'h3FFFFF0));
        tick();
        mem_ready = 1'b1; mem_rdata = {4{32'hFEED_0001}};
        @(negedge clk);
        chk1("hold_wb_dc_ready", dc_ready, 1'b1);
        chk1("hold_wb_ic_ready", ic_ready, 1'b0);
        tick();
        mem_ready = 1'b0; dc_write = 1'b0; dc_read = 1'b1; dc_addr = 30'h0000020;
        @(negedge clk);
        chk1("hold_cycle_idle_port", mem_read | mem_write, 1'b0);
        chk1("hold_cycle_no_ready", ic_ready | dc_ready, 1'b0);
        tick();
        @(negedge clk);
        chk1("hold_alloc_read", mem_read, 1'b1);
        chk1("hold_alloc_write", mem_write, 1'b0);
        chkw("hold_alloc_addr", 128'(mem_addr), 128'(30'h0000020));
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk1("hold_alloc_dc_ready", dc_ready, 1'b1);
        chk1("hold_alloc_ic_ready", ic_ready, 1'b0);
        tick();
        mem_ready = 1'b0; dc_read = 1'b0;
        @(negedge clk);
        chk1("hold_arb_cycle", mem_read, 1'b0);
        tick();
        @(negedge clk);
        chk1("hold_ic_granted", mem_read, 1'b1);
        chkw("hold_ic_addr", 128'(mem_addr), 128'(30'h0000444));
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk1("hold_ic_ready", ic_ready, 1'b1);
        tick();
        mem_ready = 1'b0; drop_all(); mem_rdata = '0;
        tick();

        // Long stall: stalled cycles never advance the watchdog
        ic_read = 1'b1; ic_addr = 30'h0000555;
        tick();
        mem_stall = 1'b1;
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (ic_stall !== 1'b1 || dc_stall !== 1'b0 || ic_ready !== 1'b0 || err_timeout !== 1'b0 || mem_read !== 1'b1)
                bad++;
            tick();
        end
        chki("stall_follow_cycles", bad, 0);
        mem_stall = 1'b0; mem_ready = 1'b1; mem_rdata = {4{32'h5A5A_0002}};
        @(negedge clk);
        chk1("stall_ic_ready", ic_ready, 1'b1);
        chk1("stall_ic_stall_clear", ic_stall, 1'b0);
        chk1("stall_no_timeout", err_timeout, 1'b0);
        chkw("stall_rdata", ic_rdata, {4{32'h5A5A_0002}});
        tick();
        mem_ready = 1'b0; drop_all(); mem_rdata = '0;
        tick();

        // Hung L2: abort after TMO non-stalled cycles past the first BUSY cycle
        dc_read = 1'b1; dc_addr = 30'h0000666;
        tick();
        bad = 0;
        for (int k = 0; k <= TMO; k++) begin
            @(negedge clk);
            if (mem_read !== 1'b1 || err_timeout !== 1'b0 || dc_ready !== 1'b0)
                bad++;
            tick();
        end
        chki("timeout_busy_window", bad, 0);
        @(negedge clk);
        chk1("timeout_flag_set", err_timeout, 1'b1);
        chk1("timeout_mem_read_drop", mem_read, 1'b0);
        chk1("timeout_no_ready", dc_ready, 1'b0);
        dc_read = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk1("timeout_flag_sticky", err_timeout, 1'b1);
        chk1("timeout_idle", mem_read | mem_write, 1'b0);
        tick();

        // Asynchronous reset in the middle of a transaction
        dc_read = 1'b1; dc_addr = 30'h0000777;
        tick();
        @(negedge clk);
        chk1("rst_mid_busy_pre", mem_read, 1'b1);
        mem_stall = 1'b1; mem_rdata = '1;
        #1;
        chk1("rst_mid_stall_pre", dc_stall, 1'b1);
        #1;
        proc_reset_n = 1'b0;
        dc_read = 1'b0;
        #1;
        chk1("rst_mid_mem_read", mem_read, 1'b0);
        chkw("rst_mid_mem_addr", 128'(mem_addr), 128'd0);
        chk1("rst_mid_stall", dc_stall, 1'b0);
        chkw("rst_mid_rdata", dc_rdata, 128'd0);
        chk1("rst_mid_err_clear", err_timeout, 1'b0);
        tick();
        proc_reset_n = 1'b1; mem_stall = 1'b0; mem_rdata = '0;
        tick();
        dc_read = 1'b1; dc_addr = 30'h0000888;
        @(negedge clk);
        chk1("post_rst_latency", mem_read, 1'b0);
        tick();
        @(negedge clk);
        chk1("post_rst_grant", mem_read, 1'b1);
        chkw("post_rst_addr", 128'(mem_addr), 128'(30'h0000888));
        tick();
        mem_ready = 1'b1; mem_rdata = {4{32'h0BAD_F00D}};
        @(negedge clk);
        chk1("post_rst_dc_ready", dc_ready, 1'b1);
        chkw("post_rst_rdata", dc_rdata, {4{32'h0BAD_F00D}});
        tick();
        mem_ready = 1'b0; drop_all();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
